// File: rtl/taillight_pkg.sv
// taillight_pkg
// Shared types and constants for the taillight bus decoder.
//   - PAT_* : six-lamp patterns {l7,l6,l5,l2,l1,l0}, bit 5 = l7
//   - lamp_class_t : classification of one lamp sample
//   - dec_state_t  : decoder FSM states
//   - mode_t       : externally visible signalling mode
// Helper functions map a lamp class onto the state it implies and a
// state onto the mode reported for it.
package taillight_pkg;

    localparam logic [5:0] PAT_OFF = 6'b000000;
    localparam logic [5:0] PAT_L1  = 6'b001000;
    localparam logic [5:0] PAT_L2  = 6'b011000;
    localparam logic [5:0] PAT_L3  = 6'b111000;
    localparam logic [5:0] PAT_R1  = 6'b000100;
    localparam logic [5:0] PAT_R2  = 6'b000110;
    localparam logic [5:0] PAT_R3  = 6'b000111;
    localparam logic [5:0] PAT_ALL = 6'b111111;

    typedef enum logic [3:0] {
        C_OFF, C_L1, C_L2, C_L3, C_R1, C_R2, C_R3, C_ALL, C_BAD
    } lamp_class_t;

    typedef enum logic [3:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HAZ, S_BAD
    } dec_state_t;

    typedef enum logic [2:0] {
        M_IDLE   = 3'd0,
        M_LEFT   = 3'd1,
        M_RIGHT  = 3'd2,
        M_HAZARD = 3'd3,
        M_BAD    = 3'd4
    } mode_t;

    // State a sample of this class resynchronises the decoder to.
    function automatic dec_state_t state_for_class(lamp_class_t c);
        dec_state_t s;
        case (c)
            C_OFF:   s = S_IDLE;
            C_L1:    s = S_L1;
            C_L2:    s = S_L2;
            C_L3:    s = S_L3;
            C_R1:    s = S_R1;
            C_R2:    s = S_R2;
            C_R3:    s = S_R3;
            C_ALL:   s = S_HAZ;
            default: s = S_BAD;
        endcase
        return s;
    endfunction

    function automatic mode_t mode_for_state(dec_state_t s);
        mode_t m;
        case (s)
            S_L1, S_L2, S_L3: m = M_LEFT;
            S_R1, S_R2, S_R3: m = M_RIGHT;
            S_HAZ:            m = M_HAZARD;
            S_BAD:            m = M_BAD;
            default:          m = M_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/taillight_decoder_classify.sv
// lamp_classify
// Purely combinational: maps one six-lamp sample onto its lamp class.
// Any pattern that is not one of the eight legal shapes is C_BAD.
//   lamps      in  6  {l7,l6,l5,l2,l1,l0}
//   lamp_class out    lamp_class_t
module lamp_classify
    import taillight_pkg::*;
(
    input  logic [5:0]  lamps,
    output lamp_class_t lamp_class
);

    always_comb begin
        case (lamps)
            PAT_OFF: lamp_class = C_OFF;
            PAT_L1:  lamp_class = C_L1;
            PAT_L2:  lamp_class = C_L2;
            PAT_L3:  lamp_class = C_L3;
            PAT_R1:  lamp_class = C_R1;
            PAT_R2:  lamp_class = C_R2;
            PAT_R3:  lamp_class = C_R3;
            PAT_ALL: lamp_class = C_ALL;
            default: lamp_class = C_BAD;
        endcase
    end

endmodule

// File: rtl/taillight_decoder.sv
// taillight_decoder
// Observes the six-lamp taillight bus, recovers the signalling mode,
// checks sequence legality and counts completed left/right sweeps.
//   clk        in  1      system clock, posedge
//   rst        in  1      asynchronous active-high reset
//   lamps      in  6      {l7,l6,l5,l2,l1,l0}
//   mode       out mode_t idle / left / right / hazard / bad
//   sweep_done out 1      pulse when L3/R3 legally follows L2/R2
//   seq_err    out 1      pulse on illegal pattern or transition
//   left_cnt   out CNT_W  completed left sweeps (saturating)
//   right_cnt  out CNT_W  completed right sweeps (saturating)
//   err_cnt    out CNT_W  seq_err events (saturating)
// Build option: define TAILLIGHT_DEC_SYNC_EN to put a 2-flop
// synchroniser in front of the sample register (latency N+3 instead
// of N+1). Decoding is identical in both builds.
module taillight_decoder
    import taillight_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int HAZ_OFF_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       lamps,
    output mode_t            mode,
    output logic             sweep_done,
    output logic             seq_err,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0]       HAZ_LIMIT = 4'(HAZ_OFF_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [5:0]  lamp_q;
    lamp_class_t cls;
    dec_state_t  state, next_state;
    logic [3:0]  off_run, off_run_next;
    logic        legal, sweep_left, sweep_right;
    mode_t       mode_next;

`ifdef TAILLIGHT_DEC_SYNC_EN
    logic [5:0] sync_1, sync_2;

    // Two synchroniser flops ahead of the sample register for lamps
    // arriving from an unrelated board clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
            lamp_q <= '0;
        end else begin
            sync_1 <= lamps;
            sync_2 <= sync_1;
            lamp_q <= sync_2;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lamp_q <= '0;
        else     lamp_q <= lamps;
    end
`endif

    lamp_classify u_classify (
        .lamps      (lamp_q),
        .lamp_class (cls)
    );

    // State register plus the hazard off-run counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            off_run <= '0;
        end else begin
            state   <= next_state;
            off_run <= off_run_next;
        end
    end

    // Next-state logic. Priority: ALL always wins (hazard overrides a
    // turn), then S_BAD waits for OFF, then a bad pattern, then the
    // hazard off-run, then repeats, then the sweep transition table.
    // An illegal transition still resynchronises to the state implied
    // by the new sample.
    always_comb begin
        next_state   = state;
        off_run_next = '0;
        legal        = 1'b1;
        sweep_left   = 1'b0;
        sweep_right  = 1'b0;
        if (cls == C_ALL) begin
            next_state = S_HAZ;
        end else if (state == S_BAD) begin
            if (cls == C_OFF) next_state = S_IDLE;
        end else if (cls == C_BAD) begin
            next_state = S_BAD;
            legal      = 1'b0;
        end else if (state == S_HAZ && cls == C_OFF) begin
            if (off_run + 4'd1 >= HAZ_LIMIT) next_state = S_IDLE;
            else                             off_run_next = off_run + 4'd1;
        end else if (state_for_class(cls) != state) begin
            next_state = state_for_class(cls);
            case (state)
                S_IDLE: legal = (cls == C_L1) || (cls == C_R1);
                S_L1:   legal = (cls == C_L2);
                S_L2: begin
                    legal      = (cls == C_L3);
                    sweep_left = (cls == C_L3);
                end
                S_L3:   legal = (cls == C_OFF) || (cls == C_L1);
                S_R1:   legal = (cls == C_R2);
                S_R2: begin
                    legal       = (cls == C_R3);
                    sweep_right = (cls == C_R3);
                end
                S_R3:   legal = (cls == C_OFF) || (cls == C_R1);
                default: legal = 1'b0;
            endcase
        end
    end

    // Mode reported for the state being entered.
    always_comb begin
        mode_next = mode_for_state(next_state);
    end

    // Registered outputs and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= M_IDLE;
            sweep_done <= 1'b0;
            seq_err    <= 1'b0;
            left_cnt   <= '0;
            right_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            mode       <= mode_next;
            sweep_done <= sweep_left | sweep_right;
            seq_err    <= ~legal;
            if (sweep_left && left_cnt != CNT_MAX)   left_cnt  <= left_cnt + CNT_ONE;
            if (sweep_right && right_cnt != CNT_MAX) right_cnt <= right_cnt + CNT_ONE;
            if (!legal && err_cnt != CNT_MAX)        err_cnt   <= err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_taillight_decoder.sv
// tb_taillight_decoder
// Scoreboard bench for taillight_decoder. Two instances share the
// lamp bus: dut (CNT_W=8) and dut_sat (CNT_W=2, for saturation).
// The driver runs a behavioural model per sample and queues the
// expected response with the cycle it is due; the monitor pops and
// compares on the falling edge of that cycle.
module tb_taillight_decoder;

`ifdef TAILLIGHT_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int HAZ = 4;

    localparam logic [5:0] P_OFF = 6'b000000;
    localparam logic [5:0] P_L1  = 6'b001000;
    localparam logic [5:0] P_L2  = 6'b011000;
    localparam logic [5:0] P_L3  = 6'b111000;
    localparam logic [5:0] P_R1  = 6'b000100;
    localparam logic [5:0] P_R2  = 6'b000110;
    localparam logic [5:0] P_R3  = 6'b000111;
    localparam logic [5:0] P_ALL = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] lamps;

    taillight_pkg::mode_t mode_a, mode_b;
    logic       sweep_a, sweep_b, err_a, err_b;
    logic [7:0] lc_a, rc_a, ec_a;
    logic [1:0] lc_b, rc_b, ec_b;

    taillight_decoder #(.CNT_W(8), .HAZ_OFF_MAX(HAZ)) dut (
        .clk(clk), .rst(rst), .lamps(lamps), .mode(mode_a),
        .sweep_done(sweep_a), .seq_err(err_a),
        .left_cnt(lc_a), .right_cnt(rc_a), .err_cnt(ec_a)
    );

    taillight_decoder #(.CNT_W(2), .HAZ_OFF_MAX(HAZ)) dut_sat (
        .clk(clk), .rst(rst), .lamps(lamps), .mode(mode_b),
        .sweep_done(sweep_b), .seq_err(err_b),
        .left_cnt(lc_b), .right_cnt(rc_b), .err_cnt(ec_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int mode;
        int sweep;
        int err;
        int lc;
        int rc;
        int ec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: model classes 0=OFF 1..3=L1..L3 4..6=R1..R3 7=ALL 8=BAD
    int m_cur, m_off_run, m_left, m_right, m_err;
    logic [5:0] pat_tab [8];

    initial begin
        pat_tab[0] = P_OFF; pat_tab[1] = P_L1; pat_tab[2] = P_L2; pat_tab[3] = P_L3;
        pat_tab[4] = P_R1;  pat_tab[5] = P_R2; pat_tab[6] = P_R3; pat_tab[7] = P_ALL;
    end

    function automatic int ref_class(logic [5:0] p);
        for (int i = 0; i < 8; i++)
            if (pat_tab[i] == p) return i;
        return 8;
    endfunction

    // Sweeps go step 1->2->3 within one side; step 3 may end (OFF) or
    // wrap to step 1 of the same side; idle may only start a sweep.
    function automatic bit ref_legal(int from, int to);
        int ff, fs, tf, ts;
        if (from == 0) return (to == 1) || (to == 4);
        if (from < 1 || from > 6) return 1'b0;
        ff = (from - 1) / 3; fs = (from - 1) % 3 + 1;
        if (to == 0) return fs == 3;
        if (to < 1 || to > 6) return 1'b0;
        tf = (to - 1) / 3; ts = (to - 1) % 3 + 1;
        if (tf != ff) return 1'b0;
        return (ts == fs + 1) || (fs == 3 && ts == 1);
    endfunction

    function automatic int ref_mode(int c);
        if (c == 0) return 0;
        if (c <= 3) return 1;
        if (c <= 6) return 2;
        if (c == 7) return 3;
        return 4;
    endfunction

    function automatic int sat(int v, int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_off_run = 0; m_left = 0; m_right = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [5:0] p, output int sw, output int er);
        int c;
        c  = ref_class(p);
        sw = 0;
        er = 0;
        if (m_cur == 8) begin
            if (c == 0 || c == 7) m_cur = c;
        end else if (c == 8) begin
            er = 1; m_cur = 8;
        end else if (c == 7) begin
            m_cur = 7;
        end else if (m_cur == 7 && c == 0) begin
            m_off_run++;
            if (m_off_run >= HAZ) m_cur = 0;
        end else if (c != m_cur) begin
            if (!ref_legal(m_cur, c)) er = 1;
            else if (c == 3 || c == 6) sw = 1;
            m_cur = c;
        end
        if (m_cur != 7 || c == 7) m_off_run = 0;
        if (sw == 1 && c == 3) m_left++;
        if (sw == 1 && c == 6) m_right++;
        if (er == 1) m_err++;
    endtask

    task automatic applyStimulus(input logic [5:0] p);
        exp_t e;
        int sw, er;
        @(negedge clk);
        lamps = p;
        model_step(p, sw, er);
        e.due   = cyc + 1 + LAT;
        e.mode  = ref_mode(m_cur);
        e.sweep = sw;
        e.err   = er;
        e.lc    = m_left;
        e.rc    = m_right;
        e.ec    = m_err;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [5:0] p, input int n);
        for (int i = 0; i < n; i++) applyStimulus(p);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check_val("mode",       32'(mode_a),  e.mode);
        check_val("sweep_done", 32'(sweep_a), e.sweep);
        check_val("seq_err",    32'(err_a),   e.err);
        check_val("left_cnt",   32'(lc_a),    sat(e.lc, 8));
        check_val("right_cnt",  32'(rc_a),    sat(e.rc, 8));
        check_val("err_cnt",    32'(ec_a),    sat(e.ec, 8));
        check_val("sat.mode",      32'(mode_b), e.mode);
        check_val("sat.left_cnt",  32'(lc_b),   sat(e.lc, 2));
        check_val("sat.right_cnt", 32'(rc_b),   sat(e.rc, 2));
        check_val("sat.err_cnt",   32'(ec_b),   sat(e.ec, 2));
    endtask

    // Monitor: compares every expected response in the cycle it is due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    checkOutput(e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [5:0] rand_valid();
        return pat_tab[$urandom_range(0, 7)];
    endfunction

    initial begin
        int r;
        rst   = 1'b1;
        lamps = P_OFF;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_val("reset.mode",    32'(mode_a), 0);
        check_val("reset.lc",      32'(lc_a),   0);
        check_val("reset.pulses",  32'({sweep_a, err_a}), 0);
        rst = 1'b0;

        hold(P_OFF, 5);
        hold(P_L1, 2); hold(P_L2, 2); hold(P_L3, 2); hold(P_OFF, 2);
        hold(P_R1, 1); hold(P_R2, 1); hold(P_R3, 1);
        hold(P_R1, 1); hold(P_R2, 1); hold(P_R3, 1); hold(P_OFF, 1);
        hold(P_ALL, 1); hold(P_OFF, 1); hold(P_ALL, 1); hold(P_OFF, 4); hold(P_OFF, 2);
        hold(P_L1, 1); hold(P_L3, 1);
        hold(6'b010101, 2); hold(6'b101010, 2); hold(P_OFF, 2);

        repeat (5) begin
            hold(P_L1, 1); hold(P_L2, 1); hold(P_L3, 1);
        end
        hold(P_L1, 1); hold(P_L2, 2);

        // Asynchronous reset in the middle of a sweep.
        @(posedge clk);
        #2;
        rst   = 1'b1;
        lamps = P_OFF;
        #1;
        check_val("async.mode",      32'(mode_a),  0);
        check_val("async.left_cnt",  32'(lc_a),    0);
        check_val("async.err_cnt",   32'(ec_a),    0);
        check_val("async.pulses",    32'({sweep_a, err_a}), 0);
        check_val("async.sat.left",  32'(lc_b),    0);
        check_val("async.sat.mode",  32'(mode_b),  0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        hold(P_L2, 1); hold(P_OFF, 1);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin
                    hold(P_L1, $urandom_range(1, 2));
                    hold(P_L2, $urandom_range(1, 2));
                    hold(P_L3, $urandom_range(1, 2));
                end
                2, 3: begin
                    hold(P_R1, $urandom_range(1, 2));
                    hold(P_R2, $urandom_range(1, 2));
                    hold(P_R3, $urandom_range(1, 2));
                end
                4: hold(P_ALL, $urandom_range(1, 3));
                5: hold(P_OFF, $urandom_range(1, 5));
                6: hold(6'($urandom), 1);
                default: hold(rand_valid(), $urandom_range(1, 2));
            endcase
        end

        hold(P_OFF, 2);
        repeat (LAT + 3) @(negedge clk);
        check_val("drain", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
